// File: rtl/mult_chunk_acc.sv
// mult_chunk_acc: multi-cycle N x N unsigned multiplier.
// The multiplier operand is consumed W = N/CC bits per cycle, LSB chunk first,
// through a single N x W multiply core, and the partial products are summed in
// a right-shifting 2N-bit accumulator. After CC RUN cycles the accumulator
// holds the full 2N-bit product, which is copied to o on entry to DONE.
//
// Handshake: start is sampled on the rising edge while the FSM is in IDLE or
// DONE; a sampled start latches g_input/e_input and enters RUN on that edge.
// start is ignored in RUN. busy is high exactly for the CC RUN cycles. done
// is a one-cycle pulse in the DONE cycle, when o first shows the new product.
// o holds its value until the next DONE. busy and done are never high together.
module mult_chunk_acc #(
  parameter int N  = 128,
  parameter int CC = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   g_input,
  input  logic [N-1:0]   e_input,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] o
);

  localparam int W  = N / CC;
  localparam int CW = (CC > 1) ? $clog2(CC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CC - 1);

  // Operand width must split evenly into CC chunks.
  if (N % CC != 0) begin : g_bad_cc
    $error("mult_chunk_acc: N must be a multiple of CC");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // FSM state is kept as a named enum so checkers can bind to it directly.
  state_t          state;
  logic [CW-1:0]   count;
  logic [N-1:0]    g_reg;
  logic [N-1:0]    e_reg;
  logic [2*N-1:0]  acc;

  logic [N+W-1:0]  partial;
  logic [2*N-1:0]  partial_ext;
  logic [2*N-1:0]  acc_next;

  // One N x W partial product per cycle; e_reg is shifted so the active chunk
  // is always its low W bits. The accumulator is shifted right by W each step
  // and the new partial enters at bit N-W, so after CC steps chunk i has been
  // moved down to weight 2^(W*i). The running value never exceeds 2^(2N)-1.
  always_comb begin
    partial     = {{W{1'b0}}, g_reg} * {{N{1'b0}}, e_reg[W-1:0]};
    partial_ext = (2*N)'(partial);
    acc_next    = (acc >> W) + (partial_ext << (N - W));
  end

  // Control FSM, operand/accumulator registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      g_reg <= '0;
      e_reg <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      o     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            g_reg <= g_input;
            e_reg <= e_input;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          e_reg <= e_reg >> W;
          count <= count + 1'b1;
          if (count == LAST) begin
            o     <= acc_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_chunk_acc.sv
// tb_mult_chunk_acc: directed and random checks of mult_chunk_acc at N=8 with
// CC = 4 (main instance), 1, 2 and 8.
module tb_mult_chunk_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  g;
  logic [7:0]  e;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [15:0] o_v [4];

  int tests_run    = 0;
  int tests_failed = 0;
  int cc_tab [4]   = '{4, 1, 2, 8};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  mult_chunk_acc #(.N(8), .CC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .g_input(g), .e_input(e),
    .busy(busy_v[0]), .done(done_v[0]), .o(o_v[0])
  );
  mult_chunk_acc #(.N(8), .CC(1)) dut_cc1 (
    .clk(clk), .rst(rst), .start(start), .g_input(g), .e_input(e),
    .busy(busy_v[1]), .done(done_v[1]), .o(o_v[1])
  );
  mult_chunk_acc #(.N(8), .CC(2)) dut_cc2 (
    .clk(clk), .rst(rst), .start(start), .g_input(g), .e_input(e),
    .busy(busy_v[2]), .done(done_v[2]), .o(o_v[2])
  );
  mult_chunk_acc #(.N(8), .CC(8)) dut_cc8 (
    .clk(clk), .rst(rst), .start(start), .g_input(g), .e_input(e),
    .busy(busy_v[3]), .done(done_v[3]), .o(o_v[3])
  );

  // driver: synchronous-looking reset pulse, ends on a negedge with all idle
  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    g     = 8'h00;
    e     = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // driver: one-cycle start pulse; returns at the first negedge after the start edge
  task automatic issue(input logic [7:0] ga, input logic [7:0] ea);
    start = 1'b1;
    g     = ga;
    e     = ea;
    @(negedge clk);
    start = 1'b0;
  endtask

  // monitor: from the current negedge (k=1) step until done on instance idx
  task automatic wait_done(input int idx, output int lat, output int busy_cnt,
                           output int overlap);
    lat      = 0;
    busy_cnt = 0;
    overlap  = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (busy_v[idx]) busy_cnt++;
      if (busy_v[idx] && done_v[idx]) overlap++;
      if (done_v[idx]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    g     = 8'h00;
    e     = 8'h00;
    @(negedge clk);
    tests_run++;
    if (busy_v[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b expected 0", busy_v[0]);
    end
    tests_run++;
    if (done_v[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_done: got %b expected 0", done_v[0]);
    end
    tests_run++;
    if (o_v[0] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_o: got %h expected 0000", o_v[0]);
    end
    tests_run++;
    if (o_v[1] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_o_cc1: got %h expected 0000", o_v[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc, ov;
    issue(8'h0D, 8'h0B);
    wait_done(0, lat, bc, ov);
    tests_run++;
    if (lat !== 5) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d expected 5", lat);
    end
    tests_run++;
    if (bc !== 4) begin
      tests_failed++;
      $display("FAIL basic_busy_cycles: got %0d expected 4", bc);
    end
    tests_run++;
    if (ov !== 0) begin
      tests_failed++;
      $display("FAIL basic_busy_done_overlap: got %0d expected 0", ov);
    end
    tests_run++;
    if (o_v[0] !== 16'h008F) begin
      tests_failed++;
      $display("FAIL basic_o: got %h expected 008f", o_v[0]);
    end
    @(negedge clk);
    tests_run++;
    if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_after_idle: got done=%b busy=%b expected 0 0", done_v[0], busy_v[0]);
    end
    tests_run++;
    if (o_v[0] !== 16'h008F) begin
      tests_failed++;
      $display("FAIL basic_o_held: got %h expected 008f", o_v[0]);
    end
  endtask

  task automatic test_max_zero();
    int lat, bc, ov;
    issue(8'hFF, 8'hFF);
    wait_done(0, lat, bc, ov);
    tests_run++;
    if (lat !== 5) begin
      tests_failed++;
      $display("FAIL max_latency: got %0d expected 5", lat);
    end
    tests_run++;
    if (o_v[0] !== 16'hFE01) begin
      tests_failed++;
      $display("FAIL max_o: got %h expected fe01", o_v[0]);
    end
    @(negedge clk);
    issue(8'h00, 8'hA5);
    tests_run++;
    if (o_v[0] !== 16'hFE01) begin
      tests_failed++;
      $display("FAIL o_held_in_run: got %h expected fe01", o_v[0]);
    end
    wait_done(0, lat, bc, ov);
    tests_run++;
    if (o_v[0] !== 16'h0000 || lat !== 5) begin
      tests_failed++;
      $display("FAIL zero_o: got o=%h lat=%0d expected 0000 5", o_v[0], lat);
    end
  endtask

  task automatic test_start_held();
    int lat, bc, ov;
    @(negedge clk);
    start = 1'b1;
    g     = 8'h12;
    e     = 8'h34;
    @(negedge clk);
    g = 8'h56;
    e = 8'h78;
    wait_done(0, lat, bc, ov);
    tests_run++;
    if (lat !== 5 || o_v[0] !== 16'h03A8) begin
      tests_failed++;
      $display("FAIL held_first: got o=%h lat=%0d expected 03a8 5", o_v[0], lat);
    end
    @(negedge clk);
    tests_run++;
    if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_rebusy: got busy=%b done=%b expected 1 0", busy_v[0], done_v[0]);
    end
    tests_run++;
    if (o_v[0] !== 16'h03A8) begin
      tests_failed++;
      $display("FAIL held_o_stable: got %h expected 03a8", o_v[0]);
    end
    start = 1'b0;
    wait_done(0, lat, bc, ov);
    // 0x56 * 0x78 = 86 * 120 = 10320
    tests_run++;
    if (lat !== 5 || o_v[0] !== 16'h2850) begin
      tests_failed++;
      $display("FAIL held_second: got o=%h lat=%0d expected 2850 5", o_v[0], lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, ov;
    @(negedge clk);
    @(negedge clk);
    issue(8'h12, 8'h34);
    wait_done(0, lat, bc, ov);
    tests_run++;
    if (lat !== 5 || o_v[0] !== 16'h03A8) begin
      tests_failed++;
      $display("FAIL b2b_first: got o=%h lat=%0d expected 03a8 5", o_v[0], lat);
    end
    issue(8'h80, 8'h02);
    wait_done(0, lat, bc, ov);
    tests_run++;
    if (lat !== 5 || o_v[0] !== 16'h0100) begin
      tests_failed++;
      $display("FAIL b2b_second: got o=%h lat=%0d expected 0100 5", o_v[0], lat);
    end
    issue(8'h0D, 8'h0B);
    wait_done(0, lat, bc, ov);
    tests_run++;
    if (lat !== 5 || o_v[0] !== 16'h008F) begin
      tests_failed++;
      $display("FAIL b2b_third: got o=%h lat=%0d expected 008f 5", o_v[0], lat);
    end
  endtask

  task automatic test_async_reset();
    int lat, bc, ov;
    @(negedge clk);
    issue(8'h0D, 8'h0B);
    wait_done(0, lat, bc, ov);
    @(negedge clk);
    issue(8'h21, 8'h07);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || o_v[0] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL async_reset: got busy=%b done=%b o=%h expected 0 0 0000",
               busy_v[0], done_v[0], o_v[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(8'h03, 8'h05);
    wait_done(0, lat, bc, ov);
    tests_run++;
    if (lat !== 5 || o_v[0] !== 16'h000F) begin
      tests_failed++;
      $display("FAIL after_reset_op: got o=%h lat=%0d expected 000f 5", o_v[0], lat);
    end
  endtask

  task automatic test_cc1();
    int lat, bc, ov;
    do_reset();
    issue(8'hC3, 8'h5A);
    wait_done(1, lat, bc, ov);
    // 0xC3 * 0x5A = 195 * 90 = 17550 = 0x448E
    tests_run++;
    if (lat !== 2) begin
      tests_failed++;
      $display("FAIL cc1_latency: got %0d expected 2", lat);
    end
    tests_run++;
    if (o_v[1] !== 16'h448E) begin
      tests_failed++;
      $display("FAIL cc1_o: got %h expected 448e", o_v[1]);
    end
  endtask

  task automatic test_random();
    logic [7:0]  ga, ea;
    logic [15:0] exp_p;
    logic [15:0] got [4];
    int          lat_a [4];
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      ga    = 8'($urandom_range(0, 255));
      ea    = 8'($urandom_range(0, 255));
      exp_p = {8'h00, ga} * {8'h00, ea};
      issue(ga, ea);
      for (int i = 0; i < 4; i++) begin
        lat_a[i] = 0;
        got[i]   = 16'h0000;
      end
      for (int k = 1; k <= 12; k++) begin
        if (k > 1) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          if (done_v[i] && lat_a[i] == 0) begin
            lat_a[i] = k;
            got[i]   = o_v[i];
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (lat_a[i] !== cc_tab[i] + 1) begin
          tests_failed++;
          $display("FAIL rand_latency cc=%0d %h*%h: got %0d expected %0d",
                   cc_tab[i], ga, ea, lat_a[i], cc_tab[i] + 1);
        end
        tests_run++;
        if (got[i] !== exp_p) begin
          tests_failed++;
          $display("FAIL rand_o cc=%0d %h*%h: got %h expected %h",
                   cc_tab[i], ga, ea, got[i], exp_p);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_zero();
    test_start_held();
    test_back_to_back();
    test_async_reset();
    test_cc1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
